// File: rtl/ib_rename_queue_pkg.sv
// ============================================================================
// ib_rename_queue_pkg : renPkt definition and sizing shared by the IB slice
// Revision: 1.0
// ============================================================================
`default_nettype none

package ib_rename_queue_pkg;

    localparam int SIZE_RMT_LOG        = 5;
    localparam int SIZE_PC             = 32;
    localparam int INST_TYPES_LOG      = 4;
    localparam int EXCEPTION_CAUSE_LOG = 4;
    localparam int IB_DEPTH_DEF        = 16;
    localparam int IB_DEPTH_LOG_DEF    = 4;

    localparam logic [EXCEPTION_CAUSE_LOG-1:0] CAUSE_SYSCALL = 4'd8;

    typedef struct packed {
        logic                           valid;
        logic [SIZE_PC-1:0]             pc;
        logic [31:0]                    inst;
        logic [INST_TYPES_LOG-1:0]      instType;
        logic [SIZE_RMT_LOG-1:0]        logDest;
        logic [SIZE_RMT_LOG-1:0]        logSrc1;
        logic [SIZE_RMT_LOG-1:0]        logSrc2;
        logic [31:0]                    immed;
        logic [SIZE_PC-1:0]             predNPC;
        logic [2:0]                     ctiID;
        logic                           exception;
        logic [EXCEPTION_CAUSE_LOG-1:0] exceptionCause;
    } renPkt;

    function automatic logic [1:0] count_valid(input renPkt a, input renPkt b);
        return {1'b0, a.valid} + {1'b0, b.valid};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ib_compact_write.sv
// ============================================================================
// ib_compact_write : packs the valid packets of a decode bundle toward slot 0
// Revision: 1.0
// ============================================================================
`default_nettype none

module ib_compact_write
    import ib_rename_queue_pkg::*;
(
    input  renPkt       pkt0,
    input  renPkt       pkt1,
    output renPkt       wr_data0,
    output renPkt       wr_data1,
    output logic        wr_en0,
    output logic        wr_en1,
    output logic [1:0]  num_wr
);

    always_comb begin
        wr_data0 = pkt0;
        wr_data1 = pkt1;
        wr_en0   = 1'b0;
        wr_en1   = 1'b0;
        unique case ({pkt1.valid, pkt0.valid})
            2'b11: begin
                wr_en0 = 1'b1;
                wr_en1 = 1'b1;
            end
            2'b01: wr_en0 = 1'b1;
            2'b10: begin
                // lone younger packet moves into the older slot
                wr_data0 = pkt1;
                wr_en0   = 1'b1;
            end
            default: ;
        endcase
        num_wr = count_valid(pkt0, pkt1);
    end

endmodule

`default_nettype wire

// File: rtl/ib_rename_queue.sv
// ============================================================================
// ib_rename_queue : two-in/two-out circular instruction buffer, decode->rename
// Revision: 1.0
// ============================================================================
`default_nettype none

module ib_rename_queue
    import ib_rename_queue_pkg::*;
#(
    parameter int IB_DEPTH     = IB_DEPTH_DEF,
    parameter int IB_DEPTH_LOG = IB_DEPTH_LOG_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic                  decodeReady_i,
    input  renPkt                 ibPacket0_i,
    input  renPkt                 ibPacket1_i,
    output logic                  stall_o,
    input  logic                  renameReady_i,
    output renPkt                 renPacket0_o,
    output renPkt                 renPacket1_o,
    output logic                  instBufValid_o,
    output logic [IB_DEPTH_LOG:0] occupancy_o
);

    localparam int CNT_W = IB_DEPTH_LOG + 1;
    localparam logic [CNT_W-1:0] STALL_LEVEL = CNT_W'(IB_DEPTH - 2);
    localparam logic [CNT_W-1:0] CNT_TWO     = CNT_W'(2);

    renPkt                   mem [IB_DEPTH];
    logic [IB_DEPTH_LOG-1:0] head_ptr;
    logic [IB_DEPTH_LOG-1:0] tail_ptr;
    logic [IB_DEPTH_LOG-1:0] head_ptr_p1;
    logic [IB_DEPTH_LOG-1:0] tail_ptr_p1;
    logic [CNT_W-1:0]        count;

    renPkt       wr_data0;
    renPkt       wr_data1;
    logic        wr_en0;
    logic        wr_en1;
    logic [1:0]  num_wr;
    logic [1:0]  num_wr_eff;
    logic [1:0]  num_rd;
    logic        do_write;
    logic        has_one;
    logic        has_two;

    ib_compact_write u_compact (
        .pkt0     (ibPacket0_i),
        .pkt1     (ibPacket1_i),
        .wr_data0 (wr_data0),
        .wr_data1 (wr_data1),
        .wr_en0   (wr_en0),
        .wr_en1   (wr_en1),
        .num_wr   (num_wr)
    );

    // Stall depends only on registered count, giving upstream a cycle of lookahead.
    assign stall_o     = (count > STALL_LEVEL);
    assign has_one     = (count != '0);
    assign has_two     = (count >= CNT_TWO);
    assign do_write    = decodeReady_i & ~stall_o & ~flush_i;
    assign num_wr_eff  = do_write ? num_wr : 2'd0;
    assign num_rd      = (renameReady_i & ~flush_i) ? (has_two ? 2'd2 : {1'b0, has_one}) : 2'd0;
    assign head_ptr_p1 = head_ptr + IB_DEPTH_LOG'(1);
    assign tail_ptr_p1 = tail_ptr + IB_DEPTH_LOG'(1);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            head_ptr <= head_ptr + IB_DEPTH_LOG'(num_rd);
            tail_ptr <= tail_ptr + IB_DEPTH_LOG'(num_wr_eff);
            count    <= count + CNT_W'(num_wr_eff) - CNT_W'(num_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_write && !reset) begin
            if (wr_en0) mem[tail_ptr]    <= wr_data0;
            if (wr_en1) mem[tail_ptr_p1] <= wr_data1;
        end
    end

    always_comb begin
        renPacket0_o       = mem[head_ptr];
        renPacket0_o.valid = has_one;
        renPacket1_o       = mem[head_ptr_p1];
        renPacket1_o.valid = has_two;
    end

    assign instBufValid_o = has_one;
    assign occupancy_o    = count;

endmodule

`default_nettype wire

// File: tb/tb_ib_rename_queue.sv
// ============================================================================
// tb_ib_rename_queue : directed stimulus with a scoreboard-checked rename port
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ib_rename_queue;
    import ib_rename_queue_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush_i;
    logic       decodeReady_i;
    renPkt      ibPacket0_i;
    renPkt      ibPacket1_i;
    logic       stall_o;
    logic       renameReady_i;
    renPkt      renPacket0_o;
    renPkt      renPacket1_o;
    logic       instBufValid_o;
    logic [4:0] occupancy_o;

    int    checks = 0;
    int    fails  = 0;
    renPkt exp_q[$];

    ib_rename_queue #(.IB_DEPTH(16), .IB_DEPTH_LOG(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (flush_i),
        .decodeReady_i  (decodeReady_i),
        .ibPacket0_i    (ibPacket0_i),
        .ibPacket1_i    (ibPacket1_i),
        .stall_o        (stall_o),
        .renameReady_i  (renameReady_i),
        .renPacket0_o   (renPacket0_o),
        .renPacket1_o   (renPacket1_o),
        .instBufValid_o (instBufValid_o),
        .occupancy_o    (occupancy_o)
    );

    always #5 clk = ~clk;

    function automatic renPkt mk(input logic v, input logic [31:0] pc);
        renPkt p;
        p.valid          = v;
        p.pc             = pc;
        p.inst           = pc ^ 32'h00A5_0013;
        p.instType       = pc[5:2];
        p.logDest        = pc[6:2];
        p.logSrc1        = pc[7:3];
        p.logSrc2        = pc[8:4];
        p.immed          = ~pc;
        p.predNPC        = pc + 32'd4;
        p.ctiID          = pc[4:2];
        p.exception      = 1'b0;
        p.exceptionCause = '0;
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_pkt(input string name, input renPkt act);
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: got pc %0h with nothing expected", name, act.pc);
        end else begin
            if (act !== exp_q[0]) begin
                fails++;
                $display("FAIL %s: got %h expected %h", name, act, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    // Monitor: every entry rename consumes must match the next expected packet.
    always @(negedge clk) begin
        if (!reset && renameReady_i && !flush_i && instBufValid_o) begin
            chk_pkt("rd_slot0", renPacket0_o);
            if (renPacket1_o.valid) chk_pkt("rd_slot1", renPacket1_o);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dr, input renPkt p0, input renPkt p1);
        decodeReady_i = dr;
        ibPacket0_i   = p0;
        ibPacket1_i   = p1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        renPkt p;
        reset         = 1'b1;
        flush_i       = 1'b0;
        renameReady_i = 1'b0;
        drive(1'b0, mk(1'b0, 32'h0), mk(1'b0, 32'h0));
        step();
        step();
        reset = 1'b0;
        chk("reset_occ", 64'(occupancy_o), 64'd0);
        chk("reset_valid", 64'(instBufValid_o), 64'd0);
        chk("reset_stall", 64'(stall_o), 64'd0);
        chk("reset_pkt1_valid", 64'(renPacket1_o.valid), 64'd0);

        // Idle with rename ready: nothing moves
        renameReady_i = 1'b1;
        repeat (3) step();
        chk("idle_occ", 64'(occupancy_o), 64'd0);
        chk("idle_valid", 64'(instBufValid_o), 64'd0);
        renameReady_i = 1'b0;

        // Compaction: lone pkt1, then lone pkt0
        drive(1'b1, mk(1'b0, 32'h1000), mk(1'b1, 32'h1004));
        exp_q.push_back(mk(1'b1, 32'h1004));
        step();
        drive(1'b1, mk(1'b1, 32'h1008), mk(1'b0, 32'h100C));
        exp_q.push_back(mk(1'b1, 32'h1008));
        step();
        drive(1'b0, mk(1'b0, 32'h0), mk(1'b0, 32'h0));
        chk("cmp_occ", 64'(occupancy_o), 64'd2);
        chk("cmp_pc0", 64'(renPacket0_o.pc), 64'h1004);
        chk("cmp_pc1", 64'(renPacket1_o.pc), 64'h1008);
        chk("cmp_valid1", 64'(renPacket1_o.valid), 64'd1);
        renameReady_i = 1'b1;
        step();
        renameReady_i = 1'b0;
        chk("cmp_drain_occ", 64'(occupancy_o), 64'd0);

        // Fill to full: 8 two-wide bundles, then a 9th that must be dropped
        for (int i = 0; i < 8; i++) begin
            chk("fill_stall_low", 64'(stall_o), 64'd0);
            drive(1'b1, mk(1'b1, 32'h2000 + 32'(i * 8)), mk(1'b1, 32'h2004 + 32'(i * 8)));
            exp_q.push_back(mk(1'b1, 32'h2000 + 32'(i * 8)));
            exp_q.push_back(mk(1'b1, 32'h2004 + 32'(i * 8)));
            step();
        end
        chk("full_stall", 64'(stall_o), 64'd1);
        chk("full_occ", 64'(occupancy_o), 64'd16);
        drive(1'b1, mk(1'b1, 32'h3000), mk(1'b1, 32'h3004));
        step();
        drive(1'b0, mk(1'b0, 32'h0), mk(1'b0, 32'h0));
        chk("drop_occ", 64'(occupancy_o), 64'd16);
        chk("drop_stall", 64'(stall_o), 64'd1);
        renameReady_i = 1'b1;
        repeat (8) step();
        chk("drain_occ", 64'(occupancy_o), 64'd0);
        chk("drain_stall", 64'(stall_o), 64'd0);

        // Streaming across many pointer wraps
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, mk(1'b1, 32'h4000 + 32'(i * 8)), mk(1'b1, 32'h4004 + 32'(i * 8)));
            exp_q.push_back(mk(1'b1, 32'h4000 + 32'(i * 8)));
            exp_q.push_back(mk(1'b1, 32'h4004 + 32'(i * 8)));
            step();
            chk("stream_occ", 64'(occupancy_o), 64'd2);
        end
        drive(1'b0, mk(1'b0, 32'h0), mk(1'b0, 32'h0));
        step();
        chk("stream_end_occ", 64'(occupancy_o), 64'd0);

        // Flush priority over a simultaneous write and read
        renameReady_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(1'b1, 32'h5000 + 32'(i * 8)), mk(1'b1, 32'h5004 + 32'(i * 8)));
            step();
        end
        chk("preflush_occ", 64'(occupancy_o), 64'd6);
        drive(1'b1, mk(1'b1, 32'h6000), mk(1'b1, 32'h6004));
        flush_i       = 1'b1;
        renameReady_i = 1'b1;
        step();
        flush_i       = 1'b0;
        renameReady_i = 1'b0;
        drive(1'b0, mk(1'b0, 32'h0), mk(1'b0, 32'h0));
        chk("flush_occ", 64'(occupancy_o), 64'd0);
        chk("flush_valid", 64'(instBufValid_o), 64'd0);
        chk("flush_stall", 64'(stall_o), 64'd0);
        renameReady_i = 1'b1;
        repeat (2) step();
        renameReady_i = 1'b0;

        // Exception fields pass through untouched
        p                = mk(1'b1, 32'h7000);
        p.exception      = 1'b1;
        p.exceptionCause = CAUSE_SYSCALL;
        drive(1'b1, p, mk(1'b0, 32'h7004));
        exp_q.push_back(p);
        step();
        drive(1'b0, mk(1'b0, 32'h0), mk(1'b0, 32'h0));
        chk("exc_flag", 64'(renPacket0_o.exception), 64'd1);
        chk("exc_cause", 64'(renPacket0_o.exceptionCause), 64'(CAUSE_SYSCALL));
        chk("exc_inst", 64'(renPacket0_o.inst), 64'(32'h7000 ^ 32'h00A5_0013));
        renameReady_i = 1'b1;
        step();
        renameReady_i = 1'b0;
        repeat (2) step();
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("final_occ", 64'(occupancy_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
